// File: rtl/l2_mem_responder_pkg.sv
// Shared widths and the posted-write entry type for the L2 word responder.
package l2_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int BEAT_W     = 3;

  // One posted write: full word address plus data.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/l2_mem_responder_if.sv
// L1-miss / L2 word interface between the cache miss handler (master) and
// the L2 responder (slave). Address is shared by reads and writes.
interface l2_mem_responder_if;
  import l2_mem_pkg::*;

  logic [WORD_W-1:0] l2_mem_access_addr;
  logic              rd_en;
  logic              l2_mem_wr_en;
  logic [WORD_W-1:0] l2_mem_wr_data;
  logic [WORD_W-1:0] l2_mem_rd_data;
  logic              rd_vld;
  logic              line_done;
  logic              wb_full;
  logic              seq_err;
  logic              addr_err;
  logic              wr_ovf;

  modport master (
    output l2_mem_access_addr, rd_en, l2_mem_wr_en, l2_mem_wr_data,
    input  l2_mem_rd_data, rd_vld, line_done, wb_full, seq_err, addr_err, wr_ovf
  );

  modport slave (
    input  l2_mem_access_addr, rd_en, l2_mem_wr_en, l2_mem_wr_data,
    output l2_mem_rd_data, rd_vld, line_done, wb_full, seq_err, addr_err, wr_ovf
  );

endinterface

// File: rtl/l2_mem_responder_wr_buf.sv
// Posted-write circular FIFO with a combinational youngest-match lookup.
// The caller guarantees no push when full without a same-cycle pop and no
// pop when empty.
module l2_wr_buf
  import l2_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  wb_entry_t         push_entry,
  output wb_entry_t         head_entry,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  input  logic [WORD_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [WORD_W-1:0] lookup_data
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  wb_entry_t        ent_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_r;

  // Next occupancy from the push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push, pop})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
    end else begin
      if (push) tail_r <= tail_r + PTR_ONE;
      if (pop)  head_r <= head_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_CNT);
    end
  end

  // Entry storage; contents need no reset since occupancy gates their use
  always_ff @(posedge clk) begin
    if (push) ent_r[tail_r] <= push_entry;
  end

  // Scan oldest to youngest so the last live match (youngest) wins
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_r) &&
          (ent_r[head_r + PTR_W'(i)].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = ent_r[head_r + PTR_W'(i)].data;
      end else begin
        lookup_hit  = lookup_hit;
        lookup_data = lookup_data;
      end
    end
  end

  assign head_entry = ent_r[head_r];
  assign full       = full_r;
  assign empty      = (count_r == '0);
  assign count      = count_r;

endmodule

// File: rtl/l2_mem_responder.sv
// L2 word responder: word array, posted write buffer with read forwarding,
// fixed-latency read pipeline and line-fill burst tracker.
module l2_mem_responder
  import l2_mem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int WB_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  l2_mem_responder_if.slave bus
);

  localparam int               CNT_W        = $clog2(WB_DEPTH) + 1;
  localparam logic [CNT_W-1:0] WB_DEPTH_CNT = CNT_W'(WB_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(1);

  logic [WORD_W-1:0]        mem_r [2**ADDR_W];

  logic [WORD_W-1:0]        addr_s;
  logic [ADDR_W-1:0]        idx_s;
  logic                     in_range_s;
  logic                     drain_s;
  logic                     wb_room_s;
  logic                     push_s;
  logic                     ovf_s;
  wb_entry_t                push_entry_s;
  wb_entry_t                wb_head_s;
  logic                     wb_full_s;
  logic                     wb_empty_s;
  logic [CNT_W-1:0]         wb_count_s;
  logic                     fwd_hit_s;
  logic [WORD_W-1:0]        fwd_data_s;
  logic [WORD_W-1:0]        rd_word_s;

  logic [BEAT_W-1:0]        beat_r;
  logic [WORD_W-BEAT_W-1:0] base_r;
  logic                     burst_err_r;
  logic                     beat_ok_s;
  logic                     burst_err_nxt_s;
  logic                     last_s;
  logic                     seq_err_r;
  logic                     addr_err_r;
  logic                     wr_ovf_r;

  logic [RD_LAT-1:0]        pv_r;
  logic [RD_LAT-1:0]        pl_r;
  logic [WORD_W-1:0]        pd_r [RD_LAT];

  logic                     unused_head_addr_s;

  assign addr_s       = bus.l2_mem_access_addr;
  assign idx_s        = addr_s[ADDR_W-1:0];
  assign in_range_s   = (addr_s[WORD_W-1:ADDR_W] == '0);
  // Reads own the array port; the buffer drains only on read-idle cycles.
  assign drain_s      = !bus.rd_en && !wb_empty_s;
  // A full buffer still accepts a write when an entry leaves the same cycle.
  assign wb_room_s    = (wb_count_s != WB_DEPTH_CNT) || drain_s;
  assign push_s       = bus.l2_mem_wr_en && in_range_s && wb_room_s;
  assign ovf_s        = bus.l2_mem_wr_en && in_range_s && !wb_room_s;
  assign push_entry_s = '{addr: addr_s, data: bus.l2_mem_wr_data};
  // Only in-range addresses are buffered, so the upper head bits carry nothing.
  assign unused_head_addr_s = ^wb_head_s.addr[WORD_W-1:ADDR_W];

  l2_wr_buf #(.DEPTH(WB_DEPTH)) u_wr_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_s),
    .pop         (drain_s),
    .push_entry  (push_entry_s),
    .head_entry  (wb_head_s),
    .full        (wb_full_s),
    .empty       (wb_empty_s),
    .count       (wb_count_s),
    .lookup_addr (addr_s),
    .lookup_hit  (fwd_hit_s),
    .lookup_data (fwd_data_s)
  );

  // Array write port: oldest buffered write retires on read-idle cycles
  always_ff @(posedge clk) begin
    if (drain_s) mem_r[wb_head_s.addr[ADDR_W-1:0]] <= wb_head_s.data;
  end

  // Read source: zero out of range, else youngest buffered write, else array
  always_comb begin
    rd_word_s = '0;
    if (!in_range_s) begin
      rd_word_s = '0;
    end else if (fwd_hit_s) begin
      rd_word_s = fwd_data_s;
    end else begin
      rd_word_s = mem_r[idx_s];
    end
  end

  // Beat check: offset must equal beat; later beats must stay in the line
  always_comb begin
    beat_ok_s = 1'b1;
    if (beat_r == '0) begin
      beat_ok_s = (addr_s[BEAT_W-1:0] == '0);
    end else begin
      beat_ok_s = (addr_s[BEAT_W-1:0] == beat_r) &&
                  (addr_s[WORD_W-1:BEAT_W] == base_r);
    end
  end

  assign burst_err_nxt_s = ((beat_r != '0) && burst_err_r) || !beat_ok_s;
  assign last_s          = (beat_r == LAST_BEAT) && !burst_err_nxt_s;

  // Burst tracker and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_r      <= '0;
      base_r      <= '0;
      burst_err_r <= 1'b0;
      seq_err_r   <= 1'b0;
      addr_err_r  <= 1'b0;
      wr_ovf_r    <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        beat_r      <= beat_r + BEAT_ONE;
        burst_err_r <= burst_err_nxt_s;
        if (beat_r == '0) base_r <= addr_s[WORD_W-1:BEAT_W];
        if (!beat_ok_s) seq_err_r <= 1'b1;
      end else begin
        // An idle cycle ends any partial burst without flagging it.
        beat_r      <= '0;
        burst_err_r <= 1'b0;
      end
      if ((bus.rd_en || bus.l2_mem_wr_en) && !in_range_s) addr_err_r <= 1'b1;
      if (ovf_s) wr_ovf_r <= 1'b1;
    end
  end

  // Read pipeline: stage 0 captures the read, later stages add latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_r <= '0;
      pl_r <= '0;
      for (int i = 0; i < RD_LAT; i++) pd_r[i] <= '0;
    end else begin
      pv_r[0] <= bus.rd_en;
      pl_r[0] <= bus.rd_en && last_s;
      pd_r[0] <= bus.rd_en ? rd_word_s : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pl_r[i] <= pl_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  assign bus.l2_mem_rd_data = pd_r[RD_LAT-1];
  assign bus.rd_vld         = pv_r[RD_LAT-1];
  assign bus.line_done      = pl_r[RD_LAT-1];
  assign bus.wb_full        = wb_full_s;
  assign bus.seq_err        = seq_err_r;
  assign bus.addr_err       = addr_err_r;
  assign bus.wr_ovf         = wr_ovf_r;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder (ADDR_W=10, RD_LAT=1, WB_DEPTH=4).
// Inputs change #1 after a rising edge; outputs are sampled at that point,
// so with RD_LAT=1 they show the result of the request sampled at the edge.
module tb_l2_mem_responder;
  import l2_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  l2_mem_responder_if bus_if();

  l2_mem_responder #(.ADDR_W(10), .RD_LAT(1), .WB_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus_if.rd_en              = rd;
    bus_if.l2_mem_wr_en       = wr;
    bus_if.l2_mem_access_addr = a;
    bus_if.l2_mem_wr_data     = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_data"},     bus_if.l2_mem_rd_data, 32'h0);
    check_eq({pfx, "_vld"},      bus_if.rd_vld,    32'h0);
    check_eq({pfx, "_done"},     bus_if.line_done, 32'h0);
    check_eq({pfx, "_full"},     bus_if.wb_full,   32'h0);
    check_eq({pfx, "_seq"},      bus_if.seq_err,   32'h0);
    check_eq({pfx, "_addrerr"},  bus_if.addr_err,  32'h0);
    check_eq({pfx, "_ovf"},      bus_if.wr_ovf,    32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    step();
    step();
    check_all_zero("rst");
    rst_n = 1'b1;
    step();

    // Preload 0x40..0x47 = 0xA0..0xA7, 0x54 = 0xBAD, 0x70 = 0x700
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 32'h40 + i, 32'hA0 + i);
      step();
    end
    drive(1'b0, 1'b1, 32'h54, 32'h0BAD); step();
    drive(1'b0, 1'b1, 32'h70, 32'h0700); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check_eq("pre_full", bus_if.wb_full, 32'h0);

    // Clean line fill
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 32'h40 + k, 32'h0);
      step();
      check_eq($sformatf("s1_vld%0d", k),  bus_if.rd_vld, 32'h1);
      check_eq($sformatf("s1_data%0d", k), bus_if.l2_mem_rd_data, 32'hA0 + k);
      check_eq($sformatf("s1_done%0d", k), bus_if.line_done, (k == 7) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_eq("s1_idle_vld", bus_if.rd_vld, 32'h0);
    check_eq("s1_idle_done", bus_if.line_done, 32'h0);
    check_eq("s1_seq", bus_if.seq_err, 32'h0);

    // Buffered write forwarded into the next burst, then drained
    drive(1'b0, 1'b1, 32'h45, 32'hDEAD);
    step();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 32'h40 + k, 32'h0);
      step();
      check_eq($sformatf("s2_data%0d", k), bus_if.l2_mem_rd_data, (k == 5) ? 32'hDEAD : 32'hA0 + k);
      check_eq($sformatf("s2_done%0d", k), bus_if.line_done, (k == 7) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    drive(1'b1, 1'b0, 32'h45, 32'h0);
    step();
    check_eq("s2_array_data", bus_if.l2_mem_rd_data, 32'hDEAD);
    check_eq("s2_single_seq", bus_if.seq_err, 32'h1);
    do_reset();
    check_eq("s2_rst_seq", bus_if.seq_err, 32'h0);

    // Out-of-order beat
    drive(1'b1, 1'b0, 32'h40, 32'h0); step();
    check_eq("s3_seq0", bus_if.seq_err, 32'h0);
    check_eq("s3_data0", bus_if.l2_mem_rd_data, 32'hA0);
    drive(1'b1, 1'b0, 32'h41, 32'h0); step();
    check_eq("s3_seq1", bus_if.seq_err, 32'h0);
    drive(1'b1, 1'b0, 32'h43, 32'h0); step();
    check_eq("s3_seq2", bus_if.seq_err, 32'h1);
    check_eq("s3_vld2", bus_if.rd_vld, 32'h1);
    check_eq("s3_data2", bus_if.l2_mem_rd_data, 32'hA3);
    check_eq("s3_done2", bus_if.line_done, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0); step();
    check_eq("s3_sticky", bus_if.seq_err, 32'h1);
    do_reset();

    // Fill the buffer under continuous reads; fifth write is dropped
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h40 + k, 32'hB0 + k);
      step();
      check_eq($sformatf("s4_data%0d", k), bus_if.l2_mem_rd_data, 32'hA0 + k);
      check_eq($sformatf("s4_full%0d", k), bus_if.wb_full, (k == 3) ? 32'h1 : 32'h0);
      check_eq($sformatf("s4_ovf%0d", k), bus_if.wr_ovf, 32'h0);
    end
    drive(1'b1, 1'b1, 32'h44, 32'hB4);
    step();
    check_eq("s4_ovf4", bus_if.wr_ovf, 32'h1);
    check_eq("s4_data4", bus_if.l2_mem_rd_data, 32'hA4);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_eq("s4_full_drain", bus_if.wb_full, 32'h0);
    for (int i = 0; i < 3; i++) step();
    check_eq("s4_ovf_sticky", bus_if.wr_ovf, 32'h1);
    drive(1'b1, 1'b0, 32'h44, 32'h0); step();
    check_eq("s4_dropped", bus_if.l2_mem_rd_data, 32'hA4);
    drive(1'b1, 1'b0, 32'h43, 32'h0); step();
    check_eq("s4_drained", bus_if.l2_mem_rd_data, 32'hB3);

    // Same-cycle write not visible, next-cycle forwarded, youngest wins
    drive(1'b0, 1'b0, 32'h0, 32'h0); step();
    drive(1'b1, 1'b1, 32'h40, 32'hC1); step();
    check_eq("s4b_pre_push", bus_if.l2_mem_rd_data, 32'hB0);
    drive(1'b1, 1'b1, 32'h40, 32'hC2); step();
    check_eq("s4b_fwd", bus_if.l2_mem_rd_data, 32'hC1);
    drive(1'b1, 1'b0, 32'h40, 32'h0); step();
    check_eq("s4b_youngest", bus_if.l2_mem_rd_data, 32'hC2);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step();

    // Out-of-range accesses
    do_reset();
    check_eq("s5_addrerr0", bus_if.addr_err, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0400, 32'h0); step();
    check_eq("s5_data", bus_if.l2_mem_rd_data, 32'h0);
    check_eq("s5_vld", bus_if.rd_vld, 32'h1);
    check_eq("s5_addrerr", bus_if.addr_err, 32'h1);
    do_reset();
    drive(1'b0, 1'b1, 32'h0000_1000, 32'h1234); step();
    check_eq("s5_wr_addrerr", bus_if.addr_err, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0); step();

    // Reset mid-burst at beat 3 with two buffered writes
    do_reset();
    drive(1'b1, 1'b1, 32'h40, 32'h7770); step();
    drive(1'b1, 1'b1, 32'h41, 32'h7771); step();
    drive(1'b1, 1'b0, 32'h42, 32'h0); step();
    drive(1'b1, 1'b0, 32'h43, 32'h0); step();
    check_eq("s6_vld3", bus_if.rd_vld, 32'h1);
    check_eq("s6_full", bus_if.wb_full, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("s6_rst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("s6_novld%0d", i), bus_if.rd_vld, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h40, 32'h0); step();
    check_eq("s6_lost0", bus_if.l2_mem_rd_data, 32'hC2);
    drive(1'b1, 1'b0, 32'h41, 32'h0); step();
    check_eq("s6_lost1", bus_if.l2_mem_rd_data, 32'hB1);
    drive(1'b0, 1'b0, 32'h0, 32'h0); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Responder side of the L1-miss/L2 word interface: services the 8-word line-fill read bursts and single-word write-throughs issued by the cache miss handler. Holds a synchronous single-port word array, a posted write buffer with read forwarding, a fixed-latency read pipeline, and a burst tracker that flags out-of-sequence line fills. Sits between the data-cache miss path and the L2 storage model in the CPU memory hierarchy.

## Interface
- ADDR_W, 10, word-address bits decoded; array depth 2**ADDR_W words
- RD_LAT, 1, cycles from rd_en sample to rd_vld; legal 1..4
- WB_DEPTH, 4, posted-write buffer entries; power of two, at least 2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- l2_mem_access_addr  in  32  word address; bits [2:0] are word-in-line
- rd_en  in  1  read request this cycle
- l2_mem_wr_en  in  1  write request this cycle
- l2_mem_wr_data  in  32  write data
- l2_mem_rd_data  out  32  read data, qualified by rd_vld
- rd_vld  out  1  l2_mem_rd_data valid
- line_done  out  1  one-cycle pulse with rd_vld of beat 7 of a clean burst
- wb_full  out  1  write buffer holds WB_DEPTH entries
- seq_err  out  1  sticky: burst beat out of order
- addr_err  out  1  sticky: access with addr[31:ADDR_W] != 0
- wr_ovf  out  1  sticky: write dropped on full buffer

## Operation
- Reads: rd_en sampled at edge N; data presented with rd_vld high after edge N+RD_LAT-1, i.e. usable at edge N+RD_LAT (RD_LAT=1: sampled next edge, as the miss handler expects). Back-to-back reads every cycle, one result per cycle, in order.
- Read source priority: youngest matching write-buffer entry, else array. Lookup uses buffer state before the same-cycle write push.
- Out-of-range read: returns 32'h0, rd_vld still asserted, addr_err set.
- Writes: l2_mem_wr_en pushes {addr, data} into buffer. Out-of-range write: not pushed, addr_err set.
- Drain: one entry (oldest) written to array per cycle when rd_en=0 and buffer non-empty; reads own the array port.
- Full buffer + wr_en: accepted if same cycle drains (rd_en=0); if rd_en=1, write dropped, wr_ovf set.
- Burst tracker: beat counter 0..7. rd_en with beat==0 latches line base addr[31:3]; each rd_en requires addr[2:0]==beat and matching base, else seq_err set (read still serviced). Beat increments per rd_en, wraps 7->0. rd_en low with beat!=0 aborts burst: beat->0, no error, no line_done.
- line_done: beat-7 read of a burst with no seq_err event within that burst.

## Timing
- Reset: l2_mem_rd_data=0, rd_vld=0, line_done=0, wb_full=0, seq_err=0, addr_err=0, wr_ovf=0; buffer pointers, beat, read pipeline cleared. Array contents not reset.
- Reset mid-burst or with buffered writes: pipeline flushed, pending writes lost, no rd_vld after reset release until new rd_en.
- wb_full registered, reflects post-edge occupancy.
- Sticky flags clear only on reset.
- Write at edge N visible to a read sampled at edge N+1 (via forwarding).

## Structure
- Package l2_mem_pkg: WORD_W=32, LINE_WORDS=8, BEAT_W=3, typedef struct wb_entry_t {addr, data}.
- Sub-module l2_wr_buf: circular FIFO (push, pop, full, empty, count) plus combinational youngest-match lookup port.
- Top holds array, read pipeline shift register (RD_LAT stages of {vld, data, last}), burst tracker.

## Test plan
- Preload words 0x40..0x47 with 0xA0..0xA7; rd_en 8 cycles addr 0x40..0x47 -> rd_vld 8 consecutive cycles, data 0xA0..0xA7, line_done with 0xA7 only.
- Write 0x45=0xDEAD, next cycle burst 0x40..0x47 -> beat 5 returns 0xDEAD while buffered; after idle drain, single read 0x45 returns 0xDEAD from array.
- Burst 0x40,0x41,0x43 -> seq_err=1 after third read, data still returned, no line_done.
- Fill buffer with 4 writes during continuous reads, 5th write with rd_en=1 -> wr_ovf=1, dropped address reads old value.
- Read addr 0x0000_0400 (ADDR_W=10) -> data 0, rd_vld=1, addr_err=1.
- Assert rst_n=0 mid-burst at beat 3 with 2 buffered writes -> all outputs 0 immediately, no rd_vld after release.
